// File: rtl/digit_renderer.sv
// Purpose: maps VGA (x,y) plus a packed BCD string to font-ROM row addresses and per-pixel on/off.
// Latency: fixed 3 cycles from an x_px/y_px sample to pixel_on; rom_addr is issued 1 cycle after the sample.
// Backpressure: none; streams one pixel per clock with no stall path (optional blink: DIGIT_BLINK_EN).
module digit_renderer #(
  parameter int ADDR_W     = 6,
  parameter int FONT_W     = 3,
  parameter int FONT_H     = 5,
  parameter int NUM_DIGITS = 6,
  parameter int BLOCK_LOG2 = 4,
  parameter int GAP_BITS   = 1,
  parameter int X0         = 40,
  parameter int Y0         = 200
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              x_px,
  input  logic [9:0]              y_px,
  input  logic                    activevideo,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    frame_tick,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [FONT_W-1:0]       rom_dout,
  output logic                    pixel_on
);

  localparam int CELL  = FONT_W + GAP_BITS;
  localparam int SUB_W = (BLOCK_LOG2 > 0) ? BLOCK_LOG2 : 1;
  // One spare bit so FONT_W itself is always representable for the glyph/gap compare.
  localparam int COL_W = $clog2(CELL + 1);
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BS_W  = (FONT_W > 1) ? $clog2(FONT_W) : 1;

  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'((1 << BLOCK_LOG2) - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(CELL - 1);
  localparam logic [COL_W-1:0] GLYPH_W = COL_W'(FONT_W);
  localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(NUM_DIGITS - 1);
  localparam logic [9:0]       X0_C    = 10'(X0);
  localparam logic [9:0]       Y0_C    = 10'(Y0);
  localparam logic [9:0]       Y_END   = 10'(Y0 + (FONT_H << BLOCK_LOG2));

  typedef struct packed {
    logic            hit;
    logic [BS_W-1:0] bitsel;
  } stage_t;

  logic [SUB_W-1:0]  sub_cnt;
  logic [COL_W-1:0]  col_cnt;
  logic [DIG_W-1:0]  dig_cnt;
  logic              running;
  stage_t            s1;
  stage_t            s2;

  logic              start_c;
  logic              run_c;
  logic [SUB_W-1:0]  cur_sub;
  logic [COL_W-1:0]  cur_col;
  logic [DIG_W-1:0]  cur_dig;
  logic              sub_wrap;
  logic              col_wrap;
  logic              dig_wrap;
  logic [3:0]        dig_val;
  logic              in_rows;
  logic              digit_ok;
  logic              blank_c;
  logic [ADDR_W-1:0] row_c;
  logic [ADDR_W-1:0] addr_c;
  stage_t            s1_c;

`ifdef DIGIT_BLINK_EN
  logic [5:0] frame_cnt;

  // Free-running frame counter; its MSB toggles every 32 frames to gate blinking digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_tick) begin
      frame_cnt <= frame_cnt + 6'd1;
    end
  end

  assign blank_c = blink_mask[cur_dig] && frame_cnt[5];
`else
  logic unused_blink;
  assign unused_blink = ^{frame_tick, blink_mask};
  assign blank_c      = 1'b0;
`endif

  // Current-pixel position within the string; the X0 pixel itself sees cleared counters.
  always_comb begin
    start_c  = activevideo && (x_px == X0_C);
    cur_sub  = start_c ? '0 : sub_cnt;
    cur_col  = start_c ? '0 : col_cnt;
    cur_dig  = start_c ? '0 : dig_cnt;
    run_c    = activevideo && (start_c || running);
    sub_wrap = (cur_sub == SUB_MAX);
    col_wrap = sub_wrap && (cur_col == COL_MAX);
    dig_wrap = col_wrap && (cur_dig == DIG_MAX);
    dig_val  = digits[{cur_dig, 2'b00} +: 4];
    in_rows  = (y_px >= Y0_C) && (y_px < Y_END);
    row_c    = ADDR_W'((y_px - Y0_C) >> BLOCK_LOG2);
    digit_ok = (dig_val <= 4'd9);
    addr_c   = digit_ok ? (ADDR_W'(dig_val) * ADDR_W'(FONT_H) + row_c) : '0;
    s1_c.hit    = run_c && in_rows && (cur_col < GLYPH_W) && digit_ok && !blank_c;
    // MSB of the ROM row is the leftmost glyph column.
    s1_c.bitsel = BS_W'(FONT_W - 1) - BS_W'(cur_col);
  end

  // Sub-pixel / column / digit counters replace any divide by the cell width.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_cnt <= '0;
      col_cnt <= '0;
      dig_cnt <= '0;
      running <= 1'b0;
    end else if (run_c) begin
      sub_cnt <= sub_wrap ? '0 : cur_sub + 1'b1;
      col_cnt <= col_wrap ? '0 : (sub_wrap ? cur_col + 1'b1 : cur_col);
      dig_cnt <= dig_wrap ? '0 : (col_wrap ? cur_dig + 1'b1 : cur_dig);
      running <= !dig_wrap;
    end else begin
      running <= 1'b0;
    end
  end

  // Three-stage pipeline: address issue, ROM access alignment, bit select.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
      s1       <= '0;
      s2       <= '0;
      pixel_on <= 1'b0;
    end else begin
      rom_addr <= addr_c;
      s1       <= s1_c;
      s2       <= s1;
      pixel_on <= s2.hit && rom_dout[s2.bitsel];
    end
  end

endmodule

// File: tb/tb_digit_renderer.sv
module tb_digit_renderer;

  localparam int X0     = 40;
  localparam int Y0     = 200;
  localparam int FONT_W = 3;
  localparam int FONT_H = 5;
  localparam int BLK    = 16;
  localparam int CELLPX = 64;
  localparam int STRW   = 384;
  localparam int BANDH  = 80;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  x_px = '0;
  logic [9:0]  y_px = '0;
  logic        activevideo = 1'b0;
  logic [23:0] digits = '0;
  logic        frame_tick = 1'b0;
  logic [5:0]  blink_mask = '0;
  logic [5:0]  rom_addr;
  logic [2:0]  rom_dout = '0;
  logic        pixel_on;

  int checks = 0;
  int failures = 0;

  logic [2:0] rom_mem [64];
  bit         started;
  int         frames;

  typedef struct {
    bit val;
    int x;
    int y;
  } exp_t;
  exp_t pq[$];

  digit_renderer dut (
    .clk(clk), .reset(reset), .x_px(x_px), .y_px(y_px), .activevideo(activevideo),
    .digits(digits), .frame_tick(frame_tick), .blink_mask(blink_mask),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .pixel_on(pixel_on)
  );

  always #5 clk = ~clk;

  // Font ROM stand-in with a 1-cycle registered read.
  always @(posedge clk) rom_dout <= rom_mem[rom_addr];

  function automatic logic [23:0] rand_digits(input int blank_idx);
    logic [23:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if (blank_idx >= 0) v[4*blank_idx +: 4] = 4'hF;
    return v;
  endfunction

  // One pixel: drive, predict from screen geometry, then check after the clock edge.
  task automatic cyc(input int x, input int y, input bit av, input bit tick);
    int pos, d, col, row, dv, ea;
    bit instr, inrows, e, achk;
    exp_t t;
    x_px = 10'(x); y_px = 10'(y); activevideo = av; frame_tick = tick;
    if (!av) started = 0;
    else if (x == X0) started = 1;
    instr  = av && started && (x >= X0) && (x < X0 + STRW);
    inrows = (y >= Y0) && (y < Y0 + BANDH);
    e = 0; achk = 0; ea = 0;
    if (instr && inrows) begin
      pos = x - X0;
      d   = pos / CELLPX;
      col = (pos / BLK) % (FONT_W + 1);
      row = (y - Y0) / BLK;
      dv  = int'(digits[4*d +: 4]);
      ea  = (dv <= 9) ? dv * FONT_H + row : 0;
      achk = 1;
      e = (col < FONT_W) && (dv <= 9) && rom_mem[ea][FONT_W-1-col];
`ifdef DIGIT_BLINK_EN
      if (blink_mask[d] && (frames % 64) >= 32) e = 0;
`endif
    end
    if (tick) frames++;
    pq.push_back('{e, x, y});
    @(posedge clk); #1;
    if (achk) begin
      checks++;
      if (rom_addr !== 6'(ea)) begin
        failures++;
        $display("FAIL rom_addr x=%0d y=%0d got=%0d want=%0d", x, y, rom_addr, ea);
      end
    end
    if (pq.size() == 3) begin
      t = pq.pop_front();
      checks++;
      if (pixel_on !== t.val) begin
        failures++;
        $display("FAIL pixel_on x=%0d y=%0d got=%b want=%b", t.x, t.y, pixel_on, t.val);
      end
    end
  endtask

  task automatic sweep(input int y, input int drop_lo, input int drop_hi);
    for (int x = X0 - 4; x <= X0 + STRW + 4; x++)
      cyc(x, y, !(x >= drop_lo && x < drop_hi), 1'b0);
  endtask

  // After a reset the pipeline output is zero for two more edges.
  task automatic after_reset();
    pq.delete();
    pq.push_back('{1'b0, -1, -1});
    pq.push_back('{1'b0, -1, -1});
    started = 0;
    frames  = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x_px = 10'($urandom); y_px = 10'($urandom); activevideo = 1'($urandom);
      digits = 24'($urandom); frame_tick = 1'($urandom); blink_mask = 6'($urandom);
      @(posedge clk); #1;
      checks++;
      if (rom_addr !== 6'd0) begin
        failures++; $display("FAIL reset_rom_addr cyc=%0d got=%0d want=0", i, rom_addr);
      end
      checks++;
      if (pixel_on !== 1'b0) begin
        failures++; $display("FAIL reset_pixel_on cyc=%0d got=%b want=0", i, pixel_on);
      end
    end
    reset = 1'b0; frame_tick = 1'b0; blink_mask = '0;
    after_reset();
  endtask

  task automatic test_sweep();
    digits = 24'h543210;
    for (int x = 0; x < 800; x++) begin
      cyc(x, Y0, x < 640, 1'b0);
      if (x >= X0 && x < X0 + STRW && ((x - X0) % CELLPX) == 0) begin
        checks++;
        if (rom_addr !== 6'(5 * ((x - X0) / CELLPX))) begin
          failures++;
          $display("FAIL cell_addr cell=%0d got=%0d want=%0d", (x - X0) / CELLPX, rom_addr, 5 * ((x - X0) / CELLPX));
        end
      end
    end
  endtask

  task automatic test_digit8();
    digits = rand_digits(-1);
    digits[3:0] = 4'd8;
    cyc(X0 - 2, Y0 + 16, 1'b1, 1'b0);
    cyc(X0 - 1, Y0 + 16, 1'b1, 1'b0);
    cyc(X0, Y0 + 16, 1'b1, 1'b0);
    checks++;
    if (rom_addr !== 6'd41) begin
      failures++; $display("FAIL digit8_addr got=%0d want=41", rom_addr);
    end
    cyc(X0 + 1, Y0 + 16, 1'b1, 1'b0);
    cyc(X0 + 2, Y0 + 16, 1'b1, 1'b0);
    checks++;
    if (pixel_on !== rom_mem[41][2]) begin
      failures++; $display("FAIL digit8_pixel got=%b want=%b", pixel_on, rom_mem[41][2]);
    end
    for (int x = X0 + 3; x <= X0 + STRW + 4; x++) cyc(x, Y0 + 16, 1'b1, 1'b0);
  endtask

  task automatic test_rows();
    int ys[4];
    ys = '{Y0 - 1, Y0 + 79, Y0 + 80, Y0 + 40};
    for (int i = 0; i < 4; i++) begin
      digits = rand_digits(-1);
      sweep(ys[i], -1, -1);
    end
    for (int i = 0; i < 4; i++) begin
      digits = rand_digits(-1);
      sweep($urandom_range(Y0 - 2, Y0 + 81), -1, -1);
    end
  endtask

  task automatic test_blank_digit();
    digits = rand_digits(2);
    for (int r = 0; r < BANDH; r += 3) sweep(Y0 + r, -1, -1);
    sweep(Y0 + BANDH - 1, -1, -1);
  endtask

  task automatic test_av_drop();
    digits = rand_digits(-1);
    sweep(Y0 + 8, X0 + 100, X0 + 110);
    sweep(Y0 + 9, -1, -1);
  endtask

  task automatic test_reset_midline();
    digits = rand_digits(-1);
    for (int x = X0 - 2; x <= X0 + 50; x++) cyc(x, Y0 + 20, 1'b1, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (pixel_on !== 1'b0) begin
        failures++; $display("FAIL midline_reset_pixel cyc=%0d got=%b want=0", i, pixel_on);
      end
    end
    reset = 1'b0;
    after_reset();
    for (int x = X0 + 53; x <= X0 + 200; x++) cyc(x, Y0 + 20, 1'b1, 1'b0);
    sweep(Y0 + 20, -1, -1);
  endtask

  task automatic test_blink();
    digits = rand_digits(-1);
    blink_mask = 6'b000001;
    for (int f = 0; f < 64; f++) begin
      sweep(Y0 + (f % 5) * BLK + 3, -1, -1);
      cyc(0, 0, 1'b0, 1'b1);
    end
    sweep(Y0 + 3, -1, -1);
    blink_mask = '0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = 3'($urandom);
    started = 0;
    frames  = 0;
    test_reset();
    test_sweep();
    test_digit8();
    test_rows();
    test_blank_digit();
    test_av_drop();
    test_reset_midline();
    test_blink();
    for (int i = 0; i < 4; i++) cyc(0, 0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
